fir_mac_seq: RTL and testbench
==============================

Name: fir_mac_seq

Overview:
- Control and datapath stage that sits around the 4-tap sample delay line (12-bit signed taps, 48-bit packed tap bus).
- Accepts input samples over a valid/ready handshake and drives the delay line's shift enable and data.
- Computes each output with a single time-multiplexed multiplier over 4 cycles, using programmable coefficients.
- Rounds and saturates the accumulator, then presents the filter output over a valid/ready handshake.

Parameters:
- C0, 12'sd64, reset value of coefficient 0 (applied to the newest sample).
- C1, 12'sd128, reset value of coefficient 1.
- C2, 12'sd128, reset value of coefficient 2.
- C3, 12'sd64, reset value of coefficient 3 (applied to the oldest sample).
- OUT_SHIFT, 8, right-shift applied to the accumulator before saturation; legal range 1..10.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  12  signed input sample
- sr_shift_en  out  1  delay-line shift enable
- sr_data  out  12  delay-line data input
- sr_taps  in  48  packed taps; [11:0]=x[n], [23:12]=x[n-1], [35:24]=x[n-2], [47:36]=x[n-3]
- coef_wr_en  in  1  coefficient write strobe
- coef_addr  in  2  coefficient index
- coef_wr_data  in  12  signed coefficient value
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts output
- out_data  out  16  signed filtered output
- busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - sr_data=in_data (combinational).
  - sr_shift_en = in_valid & in_ready (combinational).
  - On acceptance: go to MAC, idx<=0.
- MAC (4 cycles, idx 0..3), with product = sr_taps[idx]*coef[idx] (signed 12x12 -> 24 bits):
  - idx=0: acc<=product (sign-extended to 26 bits).
  - idx=1..3: acc<=acc+product.
  - After idx=3: go to OUT.
  - Taps are read in MAC, one cycle after the shift, so x[n] is the accepted sample.
- Output register, loaded on the MAC->OUT transition:
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (arithmetic shift; round half toward +inf).
  - out_data = clamp(r, -32768, 32767).
  - out_valid<=1.
- OUT:
  - out_valid and out_data are held stable until out_ready=1.
  - On out_valid&out_ready: out_valid<=0, go to IDLE.
  - No bypass: in_ready rises in the following cycle.
- Timing:
  - Sample accepted in cycle T -> out_valid high from T+5.
  - Minimum spacing between accepted samples is 6 cycles.
- in_ready=0 in MAC and OUT; in_valid there is ignored, sr_shift_en=0, and the sample is not lost (the source holds it).
- Coefficient writes:
  - Honoured only in IDLE; coef[coef_addr]<=coef_wr_data, visible from the next cycle.
  - Writes while busy are ignored.
  - A write in the same cycle as a sample acceptance is honoured and is used by that sample's MAC.
- Accumulator is 26-bit signed; no overflow is possible (|sum| <= 2^24).
- Reset, asserted at any time including mid-MAC or mid-OUT:
  - state=IDLE, idx=0, acc=0, out_valid=0, out_data=0, coef=C0..C3.
  - In-flight result discarded.
  - After release: in_ready=1, busy=0, sr_shift_en=0 unless in_valid.

Test Plan:
- Impulse, default coefs: inputs 100,0,0,0,0 -> out_data 25,50,50,25,0; first out_valid exactly 5 cycles after acceptance.
- Positive saturation: all coefs 2047, four samples 2047 -> last output acc=16760836, shifted 65472 -> out_data=32767. Negative: samples -2048 -> -32768.
- Rounding with coef0=1, others 0:
  - sample 128 -> 1; 127 -> 0.
  - -128 -> 0; -129 -> -1.
- Backpressure: out_ready=0 for 10 cycles with in_valid held high -> out_valid and out_data stable, in_ready=0, sr_shift_en never asserted. Then out_ready=1 -> one transfer, and the held sample is accepted 1 cycle later.
- Coef write during MAC (addr 0, value 0) -> ignored, result unchanged. Same write in IDLE -> next impulse output 0 on the first sample.
- rst pulsed low during MAC idx=2 -> out_valid=0, out_data=0, busy=0 immediately; coefs restored to defaults; next impulse 100 yields 25.

Source files
------------

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: handshake control and 4-cycle time-multiplexed MAC around a 4-tap sample delay line
module fir_mac_seq #(
  parameter logic signed [11:0] C0 = 12'sd64,
  parameter logic signed [11:0] C1 = 12'sd128,
  parameter logic signed [11:0] C2 = 12'sd128,
  parameter logic signed [11:0] C3 = 12'sd64,
  parameter int OUT_SHIFT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [11:0] in_data,
  output logic               sr_shift_en,
  output logic signed [11:0] sr_data,
  input  logic [47:0]        sr_taps,
  input  logic               coef_wr_en,
  input  logic [1:0]         coef_addr,
  input  logic signed [11:0] coef_wr_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  localparam logic signed [26:0] HALF = 27'sd1 <<< (OUT_SHIFT - 1);
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic signed [25:0] acc_q, acc_d, sum;
  logic out_valid_q, out_valid_d;
  logic signed [15:0] out_data_q, out_data_d, sat;
  logic signed [11:0] coef_q [4];
  logic signed [11:0] coef_d [4];
  logic signed [11:0] tap;
  logic signed [23:0] prod;
  logic signed [26:0] rnd, shr;
  assign in_ready    = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign sr_data     = in_data;
  assign sr_shift_en = in_valid & in_ready;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  // one product per MAC cycle; the running sum includes it so the last step can feed the output register directly
  always_comb begin
    tap  = idx_q == 2'd0 ? sr_taps[11:0] : idx_q == 2'd1 ? sr_taps[23:12] :
           idx_q == 2'd2 ? sr_taps[35:24] : sr_taps[47:36];
    prod = tap * coef_q[idx_q];
    sum  = (idx_q == 2'd0 ? 26'sd0 : acc_q) + 26'(prod);
    rnd  = 27'(sum) + HALF;
    shr  = rnd >>> OUT_SHIFT;
    sat  = shr > 27'sd32767 ? 16'sh7fff : shr < -27'sd32768 ? 16'sh8000 : shr[15:0];
  end
  // coefficient writes land only while idle, including the cycle a sample is accepted
  always_comb begin
    coef_d = coef_q;
    if (state_q == IDLE && coef_wr_en) coef_d[coef_addr] = coef_wr_data;
  end
  // next-state and datapath updates for IDLE -> MAC x4 -> OUT
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = MAC;
          idx_d   = 2'd0;
        end
      end
      MAC: begin
        acc_d = sum;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_data_d  = sat;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with asynchronous active-low reset that discards any in-flight result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      coef_q[0]   <= C0;
      coef_q[1]   <= C1;
      coef_q[2]   <= C2;
      coef_q[3]   <= C3;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      coef_q      <= coef_d;
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed vector table plus hand-written handshake, backpressure, coefficient and reset sequences
module tb_fir_mac_seq;
  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0, in_ready, sr_shift_en, coef_wr_en = 0, out_valid, out_ready = 0, busy;
  logic signed [11:0] in_data = 0, sr_data, coef_wr_data = 0;
  logic [1:0] coef_addr = 0;
  logic [47:0] taps;
  logic signed [15:0] out_data;
  logic dl_clr = 1;
  int checks = 0, errors = 0;
  typedef struct {
    logic wr;
    logic [47:0] cs;
    logic signed [11:0] din;
    logic signed [15:0] exp;
  } vec_t;
  vec_t v [17];
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    if (dl_clr) taps <= '0;
    else if (sr_shift_en) taps <= {taps[35:0], sr_data};
  end
  fir_mac_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sr_shift_en(sr_shift_en), .sr_data(sr_data), .sr_taps(taps),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wr_data(coef_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic wcoef(input logic [1:0] a, input logic signed [11:0] d);
    coef_wr_en = 1; coef_addr = a; coef_wr_data = d;
    @(negedge clk);
    coef_wr_en = 0;
  endtask
  task automatic clear_dl();
    dl_clr = 1;
    @(negedge clk);
    dl_clr = 0;
  endtask
  task automatic start_in(input logic signed [11:0] s);
    int n;
    in_valid = 1; in_data = s; n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready wait", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic finish_out(output logic signed [15:0] y, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("out_valid wait", int'(out_valid), 1);
    y = out_data;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  initial begin
    logic signed [15:0] y;
    int lat;
    v[0]  = '{1'b0, 48'h0, 12'sd100, 16'sd25};
    v[1]  = '{1'b0, 48'h0, 12'sd0, 16'sd50};
    v[2]  = '{1'b0, 48'h0, 12'sd0, 16'sd50};
    v[3]  = '{1'b0, 48'h0, 12'sd0, 16'sd25};
    v[4]  = '{1'b0, 48'h0, 12'sd0, 16'sd0};
    v[5]  = '{1'b1, {4{12'h7ff}}, 12'sd2047, 16'sd16368};
    v[6]  = '{1'b0, 48'h0, 12'sd2047, 16'sd32736};
    v[7]  = '{1'b0, 48'h0, 12'sd2047, 16'sd32767};
    v[8]  = '{1'b0, 48'h0, 12'sd2047, 16'sd32767};
    v[9]  = '{1'b0, 48'h0, -12'sd2048, 16'sd32728};
    v[10] = '{1'b0, 48'h0, -12'sd2048, -16'sd16};
    v[11] = '{1'b0, 48'h0, -12'sd2048, -16'sd32760};
    v[12] = '{1'b0, 48'h0, -12'sd2048, -16'sd32768};
    v[13] = '{1'b1, {12'h0, 12'h0, 12'h0, 12'h001}, 12'sd128, 16'sd1};
    v[14] = '{1'b0, 48'h0, 12'sd127, 16'sd0};
    v[15] = '{1'b0, 48'h0, -12'sd128, 16'sd0};
    v[16] = '{1'b0, 48'h0, -12'sd129, -16'sd1};
    repeat (3) @(negedge clk);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst in_ready", int'(in_ready), 1);
    rst = 1; dl_clr = 0;
    @(negedge clk);
    chk("idle shift_en low", int'(sr_shift_en), 0);
    in_data = -12'sd7; in_valid = 1;
    #1;
    chk("idle shift_en high", int'(sr_shift_en), 1);
    chk("idle sr_data", int'(sr_data), -7);
    in_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      if (v[i].wr) for (int a = 0; a < 4; a++) wcoef(2'(a), v[i].cs[a*12 +: 12]);
      start_in(v[i].din);
      finish_out(y, lat);
      chk($sformatf("vec%0d out_data", i), int'(y), int'(v[i].exp));
      if (i == 0) chk("latency", lat, 4);
    end
    start_in(12'sd500);
    in_valid = 1; in_data = 12'sd300;
    for (int n = 0; n < 50 && !out_valid; n++) begin
      chk("mac shift_en", int'(sr_shift_en), 0);
      @(negedge clk);
    end
    for (int n = 0; n < 10; n++) begin
      chk("bp out_valid", int'(out_valid), 1);
      chk("bp out_data", int'(out_data), 2);
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp shift_en", int'(sr_shift_en), 0);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp release out_valid", int'(out_valid), 0);
    chk("bp release in_ready", int'(in_ready), 1);
    chk("bp release shift_en", int'(sr_shift_en), 1);
    @(negedge clk);
    in_valid = 0;
    finish_out(y, lat);
    chk("bp held sample", int'(y), 1);
    chk("bp held latency", lat, 4);
    start_in(12'sd1000);
    coef_wr_en = 1; coef_addr = 0; coef_wr_data = 0;
    @(negedge clk);
    coef_wr_en = 0;
    finish_out(y, lat);
    chk("busy coef write ignored", int'(y), 4);
    start_in(12'sd100);
    repeat (2) @(negedge clk);
    rst = 0; dl_clr = 1;
    #1;
    chk("midmac rst out_valid", int'(out_valid), 0);
    chk("midmac rst out_data", int'(out_data), 0);
    chk("midmac rst busy", int'(busy), 0);
    chk("midmac rst in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1; dl_clr = 0;
    chk("post rst busy", int'(busy), 0);
    chk("post rst shift_en", int'(sr_shift_en), 0);
    start_in(12'sd100);
    finish_out(y, lat);
    chk("post rst impulse", int'(y), 25);
    clear_dl();
    wcoef(2'd0, 12'sd0);
    start_in(12'sd100);
    finish_out(y, lat);
    chk("idle coef write", int'(y), 0);
    clear_dl();
    coef_wr_en = 1; coef_addr = 0; coef_wr_data = 12'sd64;
    start_in(12'sd100);
    coef_wr_en = 0;
    finish_out(y, lat);
    chk("coef write at accept", int'(y), 25);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
